// File: rtl/sd_sched_pkg.sv
// Shared types and constants for the SD access scheduler.
// Build macro: SD_SCHED_4BIT_EN adds the 4-bit bus init states.
package sd_sched_pkg;

  typedef enum logic [3:0] {
    S_INIT1,
    S_INIT1_W,
`ifdef SD_SCHED_4BIT_EN
    S_INIT4,
    S_INIT4_W,
`endif
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACT,
    S_WAIT_DONE,
    S_NEXT
  } sched_state_e;

  localparam logic [1:0] MODE_INIT1 = 2'd0;
  localparam logic [1:0] MODE_READ  = 2'd1;
  localparam logic [1:0] MODE_WRITE = 2'd2;
  localparam logic [1:0] MODE_INIT4 = 2'd3;

  localparam logic [23:0] WDOG_CYCLES_DEF = 24'd16000000;

endpackage

// File: rtl/sd_sched_rr_arb.sv
// Two-requester round-robin arbiter; the last-served port loses a tie.
module sd_sched_rr_arb (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic en,
  input  logic served,
  input  logic served_port,
  output logic ack0,
  output logic ack1,
  output logic gnt_port
);

  logic last_q, last_d;

  always_comb begin
    gnt_port = 1'b0;
    if (req0 && req1) begin
      gnt_port = ~last_q;
    end else if (req1) begin
      gnt_port = 1'b1;
    end
    ack0   = en && req0 && !gnt_port;
    ack1   = en && req1 && gnt_port;
    last_d = served ? served_port : last_q;
  end

  // Reset to port 1 so port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/sd_access_sched.sv
// SD card access scheduler: init sequencing, two-port job arbitration, block
// splitting, pin-mux ownership and watchdog. Build macro: SD_SCHED_4BIT_EN.
//
// state       | meaning
// S_INIT1     | pulse reader start in 1-bit init mode
// S_INIT1_W   | wait reader busy rise then fall
// S_INIT4     | pulse reader start in 4-bit init mode (4-bit builds only)
// S_INIT4_W   | wait reader busy rise then fall (4-bit builds only)
// S_IDLE      | card ready, arbitrate requests
// S_ISSUE     | pulse reader/writer start for current sector
// S_WAIT_ACT  | wait target busy to rise
// S_WAIT_DONE | wait target block-complete pulse
// S_NEXT      | advance sector/count, finish or issue next block
module sd_access_sched
  import sd_sched_pkg::*;
#(
  parameter logic [23:0] WDOG_CYCLES = WDOG_CYCLES_DEF,
  parameter int          CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic             req0_write,
  input  logic [31:0]      req0_sector,
  input  logic [CNT_W-1:0] req0_count,
  output logic             req0_ack,
  output logic             req0_blk_done,
  output logic             req0_done,
  output logic             req0_err,
  input  logic             req1_valid,
  input  logic             req1_write,
  input  logic [31:0]      req1_sector,
  input  logic [CNT_W-1:0] req1_count,
  output logic             req1_ack,
  output logic             req1_blk_done,
  output logic             req1_done,
  output logic             req1_err,
  output logic [1:0]       rd_mode,
  output logic             rd_start,
  output logic [31:0]      rd_sector,
  input  logic             rd_busy,
  input  logic             rd_done,
  output logic             wr_start,
  output logic [31:0]      wr_sector,
  input  logic             wr_busy,
  input  logic             wr_done,
  output logic             pin_sel_wr,
  output logic             card_ready,
  output logic             grant
);

  sched_state_e     state_q, state_d;
  logic [23:0]      wdog_q, wdog_d;
  logic             seen_busy_q, seen_busy_d;
  logic             job_wr_q, job_wr_d;
  logic [31:0]      sector_q, sector_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             grant_q, grant_d;
  logic             card_ready_q, card_ready_d;
  logic             pin_sel_q, pin_sel_d;
  logic [1:0]       mode_q, mode_d;
  logic             rd_start_q, rd_start_d;
  logic             wr_start_q, wr_start_d;
  logic [31:0]      rd_sector_q, rd_sector_d;
  logic [31:0]      wr_sector_q, wr_sector_d;

  logic done_p, err_p, blk_p, served;
  logic arb_en, ack0, ack1, gnt_port;
  logic tgt_busy, tgt_done, wdog_hit;

  assign arb_en   = (state_q == S_IDLE) && card_ready_q;
  assign tgt_busy = job_wr_q ? wr_busy : rd_busy;
  assign tgt_done = job_wr_q ? wr_done : rd_done;
  assign wdog_hit = (wdog_q == WDOG_CYCLES - 24'd1);

  sd_sched_rr_arb u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0        (req0_valid),
    .req1        (req1_valid),
    .en          (arb_en),
    .served      (served),
    .served_port (grant_q),
    .ack0        (ack0),
    .ack1        (ack1),
    .gnt_port    (gnt_port)
  );

  always_comb begin
    state_d      = state_q;
    wdog_d       = wdog_q;
    seen_busy_d  = seen_busy_q;
    job_wr_d     = job_wr_q;
    sector_d     = sector_q;
    count_d      = count_q;
    grant_d      = grant_q;
    card_ready_d = card_ready_q;
    pin_sel_d    = pin_sel_q;
    mode_d       = mode_q;
    rd_sector_d  = rd_sector_q;
    wr_sector_d  = wr_sector_q;
    rd_start_d   = 1'b0;
    wr_start_d   = 1'b0;
    done_p       = 1'b0;
    err_p        = 1'b0;
    blk_p        = 1'b0;
    served       = 1'b0;

    case (state_q)
      S_INIT1: begin
        pin_sel_d = 1'b0;
        if (!rd_busy) begin
          rd_start_d  = 1'b1;
          mode_d      = MODE_INIT1;
          wdog_d      = '0;
          seen_busy_d = 1'b0;
          state_d     = S_INIT1_W;
        end
      end
      S_INIT1_W: begin
        wdog_d = wdog_q + 24'd1;
        if (wdog_hit) begin
          state_d = S_INIT1;
        end else if (!seen_busy_q) begin
          if (rd_busy) seen_busy_d = 1'b1;
        end else if (!rd_busy) begin
`ifdef SD_SCHED_4BIT_EN
          state_d = S_INIT4;
`else
          state_d      = S_IDLE;
          card_ready_d = 1'b1;
`endif
        end
      end
`ifdef SD_SCHED_4BIT_EN
      S_INIT4: begin
        if (!rd_busy) begin
          rd_start_d  = 1'b1;
          mode_d      = MODE_INIT4;
          wdog_d      = '0;
          seen_busy_d = 1'b0;
          state_d     = S_INIT4_W;
        end
      end
      S_INIT4_W: begin
        wdog_d = wdog_q + 24'd1;
        if (wdog_hit) begin
          state_d = S_INIT1;
        end else if (!seen_busy_q) begin
          if (rd_busy) seen_busy_d = 1'b1;
        end else if (!rd_busy) begin
          state_d      = S_IDLE;
          card_ready_d = 1'b1;
        end
      end
`endif
      S_IDLE: begin
        // Pin select is registered here so it leads the start pulse by a cycle.
        if (ack0 || ack1) begin
          grant_d   = gnt_port;
          job_wr_d  = gnt_port ? req1_write  : req0_write;
          sector_d  = gnt_port ? req1_sector : req0_sector;
          count_d   = gnt_port ? req1_count  : req0_count;
          pin_sel_d = gnt_port ? req1_write  : req0_write;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (count_q == '0) begin
          done_p    = 1'b1;
          served    = 1'b1;
          pin_sel_d = 1'b0;
          state_d   = S_IDLE;
        end else if (!tgt_busy) begin
          mode_d = MODE_READ;
          wdog_d = '0;
          if (job_wr_q) begin
            wr_start_d  = 1'b1;
            wr_sector_d = sector_q;
          end else begin
            rd_start_d  = 1'b1;
            rd_sector_d = sector_q;
          end
          state_d = S_WAIT_ACT;
        end
      end
      S_WAIT_ACT, S_WAIT_DONE: begin
        wdog_d = wdog_q + 24'd1;
        if (wdog_hit) begin
          done_p       = 1'b1;
          err_p        = 1'b1;
          served       = 1'b1;
          card_ready_d = 1'b0;
          pin_sel_d    = 1'b0;
          state_d      = S_INIT1;
        end else if (state_q == S_WAIT_ACT) begin
          if (tgt_busy) state_d = S_WAIT_DONE;
        end else if (tgt_done) begin
          blk_p   = 1'b1;
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        sector_d = sector_q + 32'd1;
        count_d  = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) begin
          done_p    = 1'b1;
          served    = 1'b1;
          pin_sel_d = 1'b0;
          state_d   = S_IDLE;
        end else begin
          state_d = S_ISSUE;
        end
      end
      default: state_d = S_INIT1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_INIT1;
      wdog_q       <= '0;
      seen_busy_q  <= 1'b0;
      job_wr_q     <= 1'b0;
      sector_q     <= '0;
      count_q      <= '0;
      grant_q      <= 1'b0;
      card_ready_q <= 1'b0;
      pin_sel_q    <= 1'b0;
      mode_q       <= MODE_INIT1;
      rd_start_q   <= 1'b0;
      wr_start_q   <= 1'b0;
      rd_sector_q  <= '0;
      wr_sector_q  <= '0;
    end else begin
      state_q      <= state_d;
      wdog_q       <= wdog_d;
      seen_busy_q  <= seen_busy_d;
      job_wr_q     <= job_wr_d;
      sector_q     <= sector_d;
      count_q      <= count_d;
      grant_q      <= grant_d;
      card_ready_q <= card_ready_d;
      pin_sel_q    <= pin_sel_d;
      mode_q       <= mode_d;
      rd_start_q   <= rd_start_d;
      wr_start_q   <= wr_start_d;
      rd_sector_q  <= rd_sector_d;
      wr_sector_q  <= wr_sector_d;
    end
  end

  assign req0_ack      = ack0;
  assign req1_ack      = ack1;
  assign req0_blk_done = blk_p && !grant_q;
  assign req1_blk_done = blk_p && grant_q;
  assign req0_done     = done_p && !grant_q;
  assign req1_done     = done_p && grant_q;
  assign req0_err      = err_p && !grant_q;
  assign req1_err      = err_p && grant_q;
  assign rd_mode       = mode_q;
  assign rd_start      = rd_start_q;
  assign rd_sector     = rd_sector_q;
  assign wr_start      = wr_start_q;
  assign wr_sector     = wr_sector_q;
  assign pin_sel_wr    = pin_sel_q;
  assign card_ready    = card_ready_q;
  assign grant         = grant_q;

endmodule

// File: tb/tb_sd_access_sched.sv
// Scoreboard bench for sd_access_sched with behavioural SD reader/writer models.
module tb_sd_access_sched;
  import sd_sched_pkg::*;

  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0_valid = 1'b0, req0_write = 1'b0;
  logic [31:0] req0_sector = '0;
  logic [CNT_W-1:0] req0_count = '0;
  logic req1_valid = 1'b0, req1_write = 1'b0;
  logic [31:0] req1_sector = '0;
  logic [CNT_W-1:0] req1_count = '0;
  logic req0_ack, req0_blk_done, req0_done, req0_err;
  logic req1_ack, req1_blk_done, req1_done, req1_err;
  logic [1:0] rd_mode;
  logic rd_start, wr_start, rd_busy, rd_done, wr_busy, wr_done;
  logic [31:0] rd_sector, wr_sector;
  logic pin_sel_wr, card_ready, grant;

  sd_access_sched #(.WDOG_CYCLES(24'd1000), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_sector(req0_sector),
    .req0_count(req0_count), .req0_ack(req0_ack), .req0_blk_done(req0_blk_done),
    .req0_done(req0_done), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_sector(req1_sector),
    .req1_count(req1_count), .req1_ack(req1_ack), .req1_blk_done(req1_blk_done),
    .req1_done(req1_done), .req1_err(req1_err),
    .rd_mode(rd_mode), .rd_start(rd_start), .rd_sector(rd_sector),
    .rd_busy(rd_busy), .rd_done(rd_done),
    .wr_start(wr_start), .wr_sector(wr_sector), .wr_busy(wr_busy), .wr_done(wr_done),
    .pin_sel_wr(pin_sel_wr), .card_ready(card_ready), .grant(grant)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reader: init modes busy 200 cycles, reads 4; writer busy 6. Done on last busy cycle.
  int rd_cnt = 0, wr_cnt = 0;
  logic rd_hang = 1'b0;
  always @(posedge clk) begin
    if (rd_start && !rd_hang) rd_cnt <= (rd_mode == MODE_READ) ? 4 : 200;
    else if (rd_cnt != 0)     rd_cnt <= rd_cnt - 1;
    if (wr_start)             wr_cnt <= 6;
    else if (wr_cnt != 0)     wr_cnt <= wr_cnt - 1;
  end
  assign rd_busy = (rd_cnt != 0);
  assign rd_done = (rd_cnt == 1);
  assign wr_busy = (wr_cnt != 0);
  assign wr_done = (wr_cnt == 1);

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] sec;
    bit          chk;
  } rd_exp_t;

  rd_exp_t     q_rd[$];
  logic [31:0] q_wr[$];
  int          q_ack[$];
  int          q_blk[$];   // port*2 + write
  int          q_done[$];  // port*2 + err

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops an expectation for every pulse the DUT presents.
  logic prev_pin = 1'b0;
  int rd_start_cyc = 0, ack_cyc = 0, done_cyc = 0;
  rd_exp_t e_rd;
  int e_i;
  logic [31:0] e_w;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_start) begin
        check("rd_start_expected", q_rd.size() > 0, 1);
        if (q_rd.size() > 0) begin
          e_rd = q_rd.pop_front();
          check("rd_mode", rd_mode, e_rd.mode);
          if (e_rd.chk) check("rd_sector", rd_sector, e_rd.sec);
        end
        check("pin_sel_rd_prev", prev_pin, 0);
        check("pin_sel_rd", pin_sel_wr, 0);
        rd_start_cyc = cyc;
      end
      if (wr_start) begin
        check("wr_start_expected", q_wr.size() > 0, 1);
        if (q_wr.size() > 0) begin
          e_w = q_wr.pop_front();
          check("wr_sector", wr_sector, e_w);
        end
        check("pin_sel_before_wr", prev_pin, 1);
        check("pin_sel_at_wr", pin_sel_wr, 1);
      end
      if (req0_ack || req1_ack) begin
        check("ack_single", req0_ack && req1_ack, 0);
        check("ack_card_ready", card_ready, 1);
        check("ack_expected", q_ack.size() > 0, 1);
        if (q_ack.size() > 0) begin
          e_i = q_ack.pop_front();
          check("ack_port", req1_ack, e_i);
        end
        ack_cyc = cyc;
      end
      if (req0_blk_done || req1_blk_done) begin
        check("blk_single", req0_blk_done && req1_blk_done, 0);
        check("blk_expected", q_blk.size() > 0, 1);
        if (q_blk.size() > 0) begin
          e_i = q_blk.pop_front();
          check("blk_port", req1_blk_done, e_i / 2);
          check("blk_pin_sel", pin_sel_wr, e_i % 2);
        end
      end
      if (req0_done || req1_done) begin
        check("done_single", req0_done && req1_done, 0);
        check("done_expected", q_done.size() > 0, 1);
        if (q_done.size() > 0) begin
          e_i = q_done.pop_front();
          check("done_port", req1_done, e_i / 2);
          check("done_err", req1_done ? req1_err : req0_err, e_i % 2);
        end
        done_cyc = cyc;
      end
      if (req0_err || req1_err)
        check("err_qualified", (req0_err && !req0_done) || (req1_err && !req1_done), 0);
    end
    prev_pin = pin_sel_wr;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string name);
    check({name, "_ctl"}, {req0_ack, req0_blk_done, req0_done, req0_err,
                           req1_ack, req1_blk_done, req1_done, req1_err,
                           rd_mode, rd_start, wr_start, pin_sel_wr, card_ready, grant}, 0);
    check({name, "_rd_sector"}, rd_sector, 0);
    check({name, "_wr_sector"}, wr_sector, 0);
  endtask

  task automatic push_init();
    q_rd.push_back('{mode: MODE_INIT1, sec: 32'h0, chk: 1'b0});
`ifdef SD_SCHED_4BIT_EN
    q_rd.push_back('{mode: MODE_INIT4, sec: 32'h0, chk: 1'b0});
`endif
  endtask

  task automatic expect_job(input int p, input logic w, input logic [31:0] s, input int c);
    q_ack.push_back(p);
    for (int i = 0; i < c; i++) begin
      if (w) q_wr.push_back(s + 32'(i));
      else   q_rd.push_back('{mode: MODE_READ, sec: s + 32'(i), chk: 1'b1});
      q_blk.push_back(p * 2 + int'(w));
    end
    q_done.push_back(p * 2);
  endtask

  task automatic issue_req(input int p, input logic w, input logic [31:0] s, input int c);
    if (p == 0) begin
      req0_write = w; req0_sector = s; req0_count = CNT_W'(c); req0_valid = 1'b1;
    end else begin
      req1_write = w; req1_sector = s; req1_count = CNT_W'(c); req1_valid = 1'b1;
    end
  endtask

  task automatic drop_req(input int p);
    if (p == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
  endtask

  task automatic wait_any_ack(input string name, input int bound, output int p);
    int n = 0;
    bit got = 0;
    p = 0;
    while (!got && n < bound) begin
      @(negedge clk);
      n++;
      if (req0_ack || req1_ack) begin
        got = 1;
        p = req1_ack ? 1 : 0;
      end
    end
    check({name, "_ack_in_time"}, got, 1);
  endtask

  task automatic wait_drain(input string name, input int bound);
    int n = 0;
    while ((q_rd.size() + q_wr.size() + q_ack.size() + q_blk.size() + q_done.size()) != 0
           && n < bound) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, q_rd.size() + q_wr.size() + q_ack.size() + q_blk.size() + q_done.size(), 0);
  endtask

  task automatic wait_ready(input string name, input int bound);
    int n = 0;
    while (!card_ready && n < bound) begin
      @(negedge clk);
      n++;
    end
    check({name, "_card_ready"}, card_ready, 1);
  endtask

  task automatic run_job(input string name, input int p, input logic w,
                         input logic [31:0] s, input int c);
    int ap;
    expect_job(p, w, s, c);
    step();
    issue_req(p, w, s, c);
    wait_any_ack(name, 200, ap);
    step();
    drop_req(p);
    wait_drain(name, 500);
  endtask

  int ap;

  initial begin
    #1;
    check_reset("por");
    repeat (3) step();
    push_init();
    rst_n = 1'b1;
    wait_ready("init", 1000);
    wait_drain("init", 10);

    // Both ports request together: 0, 1, 0, 1.
    expect_job(0, 1'b0, 32'h200, 1);
    expect_job(1, 1'b0, 32'h300, 1);
    expect_job(0, 1'b0, 32'h201, 1);
    expect_job(1, 1'b0, 32'h301, 1);
    step();
    issue_req(0, 1'b0, 32'h200, 1);
    issue_req(1, 1'b0, 32'h300, 1);
    for (int k = 0; k < 4; k++) begin
      wait_any_ack("alt", 300, ap);
      step();
      if (k < 2) issue_req(ap, 1'b0, (ap == 0) ? 32'h201 : 32'h301, 1);
      else       drop_req(ap);
    end
    wait_drain("alt", 300);

    run_job("rd3", 0, 1'b0, 32'h0000_0100, 3);
    run_job("wrwrap", 1, 1'b1, 32'hFFFF_FFFF, 2);

    run_job("cnt0", 0, 1'b0, 32'h55, 0);
    check("cnt0_done_latency", done_cyc - ack_cyc, 1);

    // Watchdog: reader ignores start, job aborts and card re-inits.
    rd_hang = 1'b1;
    q_ack.push_back(0);
    q_rd.push_back('{mode: MODE_READ, sec: 32'h60, chk: 1'b1});
    q_done.push_back(1);
    step();
    issue_req(0, 1'b0, 32'h60, 2);
    wait_any_ack("wdog", 200, ap);
    step();
    drop_req(0);
    wait_drain("wdog", 1500);
    check("wdog_latency_ok", (done_cyc - rd_start_cyc >= 995) && (done_cyc - rd_start_cyc <= 1005), 1);
    step();
    check("wdog_card_ready_drop", card_ready, 0);
    rd_hang = 1'b0;
    push_init();
    // Request during re-init must be held until card_ready.
    expect_job(0, 1'b0, 32'h70, 1);
    issue_req(0, 1'b0, 32'h70, 1);
    wait_any_ack("reinit", 1500, ap);
    step();
    drop_req(0);
    wait_drain("reinit", 300);

    // Reset in the middle of a block: no done for the lost job.
    q_ack.push_back(1);
    q_rd.push_back('{mode: MODE_READ, sec: 32'h400, chk: 1'b1});
    step();
    issue_req(1, 1'b0, 32'h400, 3);
    wait_any_ack("midrst", 200, ap);
    step();
    drop_req(1);
    wait_drain("midrst", 50);
    step();
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    repeat (3) step();
    push_init();
    rst_n = 1'b1;
    wait_ready("midrst_init", 1000);
    wait_drain("midrst_init", 10);
    run_job("recover", 0, 1'b0, 32'h500, 1);

    repeat (20) step();
    check("final_queues_empty", q_rd.size() + q_wr.size() + q_ack.size() + q_blk.size() + q_done.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
